// File: rtl/cw_pkg.sv
// Shared CW definitions: symbol codes, transmitter state encoding and
// default unit counts. The CW receiver uses the same symbol codes.
package cw_pkg;

  // Symbol request codes carried on sym_code
  localparam logic [1:0] SYM_DOT  = 2'd0;
  localparam logic [1:0] SYM_DASH = 2'd1;
  localparam logic [1:0] SYM_CHAR = 2'd2;
  localparam logic [1:0] SYM_WORD = 2'd3;

  // Transmitter phase
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

  // Default timing, in Morse units (clock cycles for UNIT_CYCLES)
  localparam int DEF_UNIT_CYCLES     = 1;
  localparam int DEF_DOT_UNITS       = 1;
  localparam int DEF_DASH_UNITS      = 4;
  localparam int DEF_INTRA_GAP_UNITS = 1;
  localparam int DEF_CHAR_GAP_UNITS  = 3;
  localparam int DEF_WORD_GAP_UNITS  = 8;

  // Counter widths
  localparam int PRESC_W    = 16;
  localparam int UNIT_CNT_W = 4;
  localparam int UNIT_MAX   = (1 << UNIT_CNT_W) - 1;

  // True for symbols that key the carrier
  function automatic logic is_mark_sym(input logic [1:0] code);
    return (code == SYM_DOT) || (code == SYM_DASH);
  endfunction

endpackage

// File: rtl/cw_unit_tick.sv
// Unit prescaler: counts 0..UNIT_CYCLES-1 and flags the last cycle of each
// Morse unit. A restart forces the count back to 0 for the next cycle so
// every phase begins on a fresh unit boundary.
module cw_unit_tick
  import cw_pkg::*;
#(
  parameter int UNIT_CYCLES = DEF_UNIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick,
  output logic o_tick_next
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(UNIT_CYCLES - 1);

  logic [PRESC_W-1:0] r_cnt;
  logic [PRESC_W-1:0] w_cnt_next;

  assign o_tick = (r_cnt == LAST);

  // Next prescaler value: wrap on tick, clear on restart, else count up
  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    w_cnt_next = '0;
    if (!i_restart && !o_tick) begin
      w_cnt_next = r_cnt + PRESC_W'(1);
    end
  end

  // Lets the owner predict a tick one cycle ahead for registered outputs
  assign o_tick_next = (w_cnt_next == LAST);

  // Prescaler register
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments for state so all flops update together at the edge.
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

endmodule

// File: rtl/tx_cw_m.sv
// CW keyer transmitter. Takes dot/dash/char-space/word-space requests over a
// valid/ready handshake and keys tx_cw with unit-exact mark and gap timing.
// A request offered in the final gap cycle chains with no extra low cycle.
module tx_cw_m
  import cw_pkg::*;
#(
  parameter int UNIT_CYCLES     = DEF_UNIT_CYCLES,
  parameter int DOT_UNITS       = DEF_DOT_UNITS,
  parameter int DASH_UNITS      = DEF_DASH_UNITS,
  parameter int INTRA_GAP_UNITS = DEF_INTRA_GAP_UNITS,
  parameter int CHAR_GAP_UNITS  = DEF_CHAR_GAP_UNITS,
  parameter int WORD_GAP_UNITS  = DEF_WORD_GAP_UNITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sym_valid,
  input  logic [1:0] sym_code,
  output logic       sym_ready,
  output logic       tx_cw,
  output logic       busy,
  output logic       sym_done
);

  // Elaboration-time parameter legality
  if (UNIT_CYCLES < 1 || UNIT_CYCLES > 65535) begin : g_bad_unit_cycles
    $error("tx_cw_m: UNIT_CYCLES must be 1..65535");
  end
  if (DOT_UNITS < 1 || DOT_UNITS > UNIT_MAX ||
      DASH_UNITS < 1 || DASH_UNITS > UNIT_MAX) begin : g_bad_mark_units
    $error("tx_cw_m: DOT_UNITS and DASH_UNITS must be 1..15");
  end
  if (INTRA_GAP_UNITS < 0 || INTRA_GAP_UNITS > UNIT_MAX ||
      CHAR_GAP_UNITS > UNIT_MAX || WORD_GAP_UNITS > UNIT_MAX) begin : g_bad_gap_units
    $error("tx_cw_m: gap unit parameters must be <= 15");
  end
  if (CHAR_GAP_UNITS < INTRA_GAP_UNITS ||
      WORD_GAP_UNITS < INTRA_GAP_UNITS) begin : g_bad_gap_order
    $error("tx_cw_m: CHAR/WORD gap must be >= INTRA_GAP_UNITS");
  end

  // Unit-count loads; a space only adds what the preceding intra gap lacks
  localparam logic [UNIT_CNT_W-1:0] DOT_L   = UNIT_CNT_W'(DOT_UNITS);
  localparam logic [UNIT_CNT_W-1:0] DASH_L  = UNIT_CNT_W'(DASH_UNITS);
  localparam logic [UNIT_CNT_W-1:0] INTRA_L = UNIT_CNT_W'(INTRA_GAP_UNITS);
  localparam logic [UNIT_CNT_W-1:0] CHAR_L  = UNIT_CNT_W'(CHAR_GAP_UNITS - INTRA_GAP_UNITS);
  localparam logic [UNIT_CNT_W-1:0] WORD_L  = UNIT_CNT_W'(WORD_GAP_UNITS - INTRA_GAP_UNITS);

  tx_state_e             r_state;
  tx_state_e             w_state_next;
  logic [UNIT_CNT_W-1:0] r_units;
  logic [UNIT_CNT_W-1:0] w_units_next;
  logic                  w_restart;
  logic                  w_tick;
  logic                  w_tick_next;
  logic                  w_accept;
  logic                  w_gap_end;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;

  cw_unit_tick #(
    .UNIT_CYCLES (UNIT_CYCLES)
  ) u_unit_tick (
    .clk         (clk),
    .rst         (rst),
    .i_restart   (w_restart),
    .o_tick      (w_tick),
    .o_tick_next (w_tick_next)
  );

  // A zero-length gap occupies a single cycle and ends immediately
  assign w_gap_end = (r_state == GAP) &&
                     ((r_units == '0) || (w_tick && (r_units == UNIT_CNT_W'(1))));
  assign sym_ready = (r_state == IDLE) || w_gap_end;
  assign w_accept  = sym_valid && sym_ready;

  // Next state, unit counter and prescaler restart
  always_comb begin
    w_state_next = r_state;
    w_units_next = r_units;
    w_restart    = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_restart    = 1'b1;
        w_units_next = '0;
      end
      MARK: begin
        if (w_tick) begin
          if (r_units <= UNIT_CNT_W'(1)) begin
            w_state_next = GAP;
            w_units_next = INTRA_L;
            w_restart    = 1'b1;
          end else begin
            w_units_next = r_units - UNIT_CNT_W'(1);
          end
        end
      end
      GAP: begin
        if (w_gap_end) begin
          w_state_next = IDLE;
          w_units_next = '0;
          w_restart    = 1'b1;
        end else if (w_tick) begin
          w_units_next = r_units - UNIT_CNT_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
        w_units_next = '0;
        w_restart    = 1'b1;
      end
    endcase

    // Accept is only possible in IDLE or the final gap cycle; it starts the new phase
    if (w_accept) begin
      w_restart = 1'b1;
      if (is_mark_sym(sym_code)) begin
        w_state_next = MARK;
        w_units_next = (sym_code == SYM_DOT) ? DOT_L : DASH_L;
      end else begin
        w_state_next = GAP;
        w_units_next = (sym_code == SYM_CHAR) ? CHAR_L : WORD_L;
      end
    end
  end

  // State, unit counter and registered outputs; sym_done is predicted one cycle ahead
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_units <= '0;
      r_tx    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_units <= w_units_next;
      r_tx    <= (w_state_next == MARK);
      r_busy  <= (w_state_next != IDLE);
      r_done  <= (w_state_next == GAP) &&
                 ((w_units_next == '0) ||
                  ((w_units_next == UNIT_CNT_W'(1)) && w_tick_next));
    end
  end

  assign tx_cw    = r_tx;
  assign busy     = r_busy;
  assign sym_done = r_done;

endmodule

// File: tb/tb_tx_cw_m.sv
// Bench for tx_cw_m: reset checks, a per-cycle vector table, hand-written
// timing sequences, and randomized traffic against an interval-based model.
module tb_tx_cw_m;

  // Default timing as described for the keyer
  localparam int DOT   = 1;
  localparam int DASH  = 4;
  localparam int INTRA = 1;
  localparam int CHARG = 3;
  localparam int WORDG = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       v1 = 1'b0, v5 = 1'b0;
  logic [1:0] c1 = 2'd0, c5 = 2'd0;
  logic       r1, t1, b1, d1;
  logic       r5, t5, b5, d5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tx_cw_m #(.UNIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .sym_valid(v1), .sym_code(c1),
    .sym_ready(r1), .tx_cw(t1), .busy(b1), .sym_done(d1)
  );

  tx_cw_m #(.UNIT_CYCLES(5)) dut5 (
    .clk(clk), .rst(rst), .sym_valid(v5), .sym_code(c5),
    .sym_ready(r5), .tx_cw(t5), .busy(b5), .sym_done(d5)
  );

  typedef struct packed {
    logic       v;
    logic [1:0] code;
    logic       tx;
    logic       busy;
    logic       done;
    logic       rdy;
  } vec_t;

  vec_t tbl [16];

  bit tr_tx[$], tr_rdy[$], tr_done[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sample(input int which, output logic rdy, output logic tx,
                        output logic bsy, output logic dn);
    if (which == 1) begin
      rdy = r1; tx = t1; bsy = b1; dn = d1;
    end else begin
      rdy = r5; tx = t5; bsy = b5; dn = d5;
    end
  endtask

  task automatic drive(input int which, input logic v, input logic [1:0] code);
    if (which == 1) begin
      v1 = v; c1 = code;
    end else begin
      v5 = v; c5 = code;
    end
  endtask

  // Leaves the bench just after a negedge with both DUTs idle
  task automatic do_reset();
    v1 = 1'b0; v5 = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  function automatic int mark_cycles(input int uc, input logic [1:0] code);
    if (code == 2'd0) return DOT * uc;
    if (code == 2'd1) return DASH * uc;
    return 0;
  endfunction

  function automatic int total_cycles(input int uc, input logic [1:0] code);
    int gap_units;
    if (code < 2'd2)       gap_units = INTRA;
    else if (code == 2'd2) gap_units = CHARG - INTRA;
    else                   gap_units = WORDG - INTRA;
    return mark_cycles(uc, code) + ((gap_units == 0) ? 1 : gap_units * uc);
  endfunction

  // Offers up to three symbols, each only when the DUT is ready, and records
  // the outputs of every busy cycle until the block goes idle again.
  task automatic run_seq(input int which, input int n, input logic [1:0] s0,
                         input logic [1:0] s1, input logic [1:0] s2, input int budget);
    logic rdy, tx, bsy, dn;
    logic [1:0] codes [3];
    int idx = 0;
    bit finished = 0;
    codes[0] = s0; codes[1] = s1; codes[2] = s2;
    tr_tx.delete(); tr_rdy.delete(); tr_done.delete();
    for (int cyc = 0; cyc < budget; cyc++) begin
      sample(which, rdy, tx, bsy, dn);
      if (bsy) begin
        tr_tx.push_back(tx); tr_rdy.push_back(rdy); tr_done.push_back(dn);
      end
      if (idx == n && !bsy && cyc > 0) begin
        finished = 1;
        break;
      end
      if (idx < n && rdy) begin
        drive(which, 1'b1, codes[idx]);
        idx++;
      end else begin
        drive(which, 1'b0, 2'd0);
      end
      @(negedge clk);
    end
    drive(which, 1'b0, 2'd0);
    if (!finished) check("seq_timeout", 32'd1, 32'd0);
  endtask

  // First mark length and the low run that follows it within the busy trace
  task automatic trace_runs(output int hi, output int lo, output int dones,
                            output int rdys, output bit last_rdy);
    int i = 0;
    hi = 0; lo = 0; dones = 0; rdys = 0;
    while (i < tr_tx.size() && !tr_tx[i]) i++;
    while (i < tr_tx.size() && tr_tx[i]) begin hi++; i++; end
    while (i < tr_tx.size() && !tr_tx[i]) begin lo++; i++; end
    foreach (tr_done[k]) if (tr_done[k]) dones++;
    foreach (tr_rdy[k]) if (tr_rdy[k]) rdys++;
    last_rdy = (tr_rdy.size() > 0) ? tr_rdy[tr_rdy.size() - 1] : 1'b0;
  endtask

  // Random traffic; the model knows only the last accept cycle and the
  // mark/total durations of that symbol.
  task automatic run_random(input int which, input int uc, input int ncyc);
    logic rdy, tx, bsy, dn;
    logic v;
    logic [1:0] code;
    int acc = -1000000, mlen = 0, len = 0;
    bit in_sym, e_tx, e_done, e_rdy;
    for (int c = 0; c < ncyc; c++) begin
      sample(which, rdy, tx, bsy, dn);
      in_sym = (c > acc) && (c <= acc + len);
      e_tx   = in_sym && (c <= acc + mlen);
      e_done = in_sym && (c == acc + len);
      e_rdy  = !in_sym || e_done;
      check($sformatf("rnd_u%0d_tx@%0d", uc, c),    32'(tx),  32'(e_tx));
      check($sformatf("rnd_u%0d_busy@%0d", uc, c),  32'(bsy), 32'(in_sym));
      check($sformatf("rnd_u%0d_done@%0d", uc, c),  32'(dn),  32'(e_done));
      check($sformatf("rnd_u%0d_ready@%0d", uc, c), 32'(rdy), 32'(e_rdy));
      v    = ($urandom_range(0, 9) < 6);
      code = 2'($urandom_range(0, 3));
      drive(which, v, code);
      if (v && e_rdy) begin
        acc  = c;
        mlen = mark_cycles(uc, code);
        len  = total_cycles(uc, code);
      end
      @(negedge clk);
    end
    drive(which, 1'b0, 2'd0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rdy, tx, bsy, dn;
    int hi, lo, dones, rdys;
    bit last_rdy;

    // Rows: inputs applied this cycle, outputs expected this cycle (UNIT_CYCLES=1)
    //            v     code   tx    busy  done  rdy
    tbl[0]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1}; // accept dash
    tbl[1]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0}; // junk while busy
    tbl[3]  = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0}; // junk while busy
    tbl[4]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1}; // chain dot
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1}; // accept dot
    tbl[9]  = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1}; // chain char space
    tbl[11] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1}; // chain dot
    tbl[13] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    do_reset();
    sample(1, rdy, tx, bsy, dn);
    check("rst_tx",    32'(tx),  32'd0);
    check("rst_busy",  32'(bsy), 32'd0);
    check("rst_done",  32'(dn),  32'd0);
    check("rst_ready", 32'(rdy), 32'd1);
    sample(5, rdy, tx, bsy, dn);
    check("rst5_tx",   32'(tx),  32'd0);
    check("rst5_busy", 32'(bsy), 32'd0);

    // Vector table
    for (int i = 0; i < 16; i++) begin
      sample(1, rdy, tx, bsy, dn);
      check($sformatf("tbl%0d_tx", i),    32'(tx),  32'(tbl[i].tx));
      check($sformatf("tbl%0d_busy", i),  32'(bsy), 32'(tbl[i].busy));
      check($sformatf("tbl%0d_done", i),  32'(dn),  32'(tbl[i].done));
      check($sformatf("tbl%0d_ready", i), 32'(rdy), 32'(tbl[i].rdy));
      drive(1, tbl[i].v, tbl[i].code);
      @(negedge clk);
    end
    drive(1, 1'b0, 2'd0);

    // Reset mid-dash: outputs drop without any clock edge
    drive(1, 1'b1, 2'd1);
    @(negedge clk);
    drive(1, 1'b0, 2'd0);
    @(negedge clk);
    sample(1, rdy, tx, bsy, dn);
    check("middash_tx_before", 32'(tx), 32'd1);
    #2 rst = 1'b0;
    #1;
    sample(1, rdy, tx, bsy, dn);
    check("middash_tx_async",   32'(tx),  32'd0);
    check("middash_busy_async", 32'(bsy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1'b1, 2'd0);
    @(negedge clk);
    drive(1, 1'b0, 2'd0);
    sample(1, rdy, tx, bsy, dn);
    check("post_rst_dot_tx",    32'(tx),  32'd1);
    check("post_rst_dot_ready", 32'(rdy), 32'd0);
    @(negedge clk);
    sample(1, rdy, tx, bsy, dn);
    check("post_rst_gap_tx",    32'(tx),  32'd0);
    check("post_rst_gap_done",  32'(dn),  32'd1);
    check("post_rst_gap_ready", 32'(rdy), 32'd1);
    @(negedge clk);
    sample(1, rdy, tx, bsy, dn);
    check("post_rst_idle_busy",  32'(bsy), 32'd0);
    check("post_rst_idle_ready", 32'(rdy), 32'd1);

    // Dot, char space, dot: 3 low cycles between marks
    run_seq(1, 3, 2'd0, 2'd2, 2'd0, 200);
    trace_runs(hi, lo, dones, rdys, last_rdy);
    check("dcd_mark",  32'(hi),    32'd1);
    check("dcd_low",   32'(lo),    32'd3);
    check("dcd_dones", 32'(dones), 32'd3);

    // Dot, word space, dot: 8 low cycles between marks
    run_seq(1, 3, 2'd0, 2'd3, 2'd0, 200);
    trace_runs(hi, lo, dones, rdys, last_rdy);
    check("dwd_mark",  32'(hi),    32'd1);
    check("dwd_low",   32'(lo),    32'd8);
    check("dwd_dones", 32'(dones), 32'd3);

    // UNIT_CYCLES=5 dash: 20 high, 5 low, ready only in the final gap cycle
    run_seq(5, 1, 2'd1, 2'd0, 2'd0, 200);
    trace_runs(hi, lo, dones, rdys, last_rdy);
    check("u5_dash_high",   32'(hi),       32'd20);
    check("u5_dash_low",    32'(lo),       32'd5);
    check("u5_dash_done",   32'(dones),    32'd1);
    check("u5_ready_count", 32'(rdys),     32'd1);
    check("u5_ready_last",  32'(last_rdy), 32'd1);

    // Randomized traffic against the model
    do_reset();
    run_random(1, 1, 500);
    do_reset();
    run_random(5, 5, 700);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
